edp_mds: RTL and testbench

EDP_MDS -- requirements
Module: edp_mds

---
 rtl/edp_mds_pkg.sv | 21 ++
 rtl/edp_mds_cneg.sv | 12 +
 rtl/edp_mds.sv | 186 ++++++++++++++++++
 tb/tb_edp_mds.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/edp_mds_pkg.sv
// Shared types and constants for the edp_mds sequential multiply/divide unit.
package edp_mds_pkg;

    localparam int EDP_MDS_WIDTH = 36;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MULS = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIVS = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_e;

endpackage

// File: rtl/edp_mds_cneg.sv
// mds_cneg: conditional two's-complement negate of an N-bit word.
module mds_cneg #(
    parameter int N = 8
) (
    input  logic [N-1:0] x_i,
    input  logic         neg_i,
    output logic [N-1:0] y_o
);

    assign y_o = neg_i ? (~x_i + N'(1)) : x_i;

endmodule

// File: rtl/edp_mds.sv
// edp_mds: iterative MULU/MULS/DIVU/DIVS unit, one quotient/product bit per cycle.
// Optional macro EDP_MDS_EARLY_OUT_EN ends multiply RUN once the multiplier is exhausted.
module edp_mds
    import edp_mds_pkg::*;
#(
    parameter int WIDTH = EDP_MDS_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_hi,
    input  logic [WIDTH-1:0] a_lo,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             nodiv,
    output logic             busy
);

    localparam int W  = WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e          state_q;
    op_e             op_q;
    logic [W-1:0]    a_hi_q, a_lo_q, b_q;
    logic [2*W-1:0]  prod_q, mcand_q;
    logic [W-1:0]    mplier_q;
    logic [W+1:0]    rem_q;
    logic            qneg_q, rneg_q;
    logic [CW-1:0]   cnt_q;
    logic            start_ready_q, busy_q, result_valid_q, nodiv_q;
    logic [W-1:0]    res_hi_q, res_lo_q;

    logic            is_div, is_sgn;
    logic [2*W-1:0]  cna_x, cna_y;
    logic            cna_neg;
    logic [W-1:0]    cnb_x, cnb_y, cnr_y;
    logic            cnb_neg;
    logic [2*W-1:0]  mul_sum;
    logic [W+1:0]    rem_sh, rem_nx, div_b;
    logic [W-1:0]    rem_fix;
    logic            nd, run_last;

    assign is_div = (op_q == OP_DIVU) || (op_q == OP_DIVS);
    assign is_sgn = (op_q == OP_MULS) || (op_q == OP_DIVS);

    // The negators are shared: operand magnitudes in PREP, sign correction in FIX.
    always_comb begin
        if (state_q == ST_FIX) begin
            cna_x   = prod_q;
            cna_neg = qneg_q;
            cnb_x   = mplier_q;
            cnb_neg = qneg_q;
        end else begin
            cna_x   = is_div ? {a_hi_q, a_lo_q} : {{W{is_sgn & a_lo_q[W-1]}}, a_lo_q};
            cna_neg = is_sgn & cna_x[2*W-1];
            cnb_x   = b_q;
            cnb_neg = is_sgn & b_q[W-1];
        end
    end

    mds_cneg #(.N(2*W)) u_cneg_a (.x_i(cna_x),   .neg_i(cna_neg), .y_o(cna_y));
    mds_cneg #(.N(W))   u_cneg_b (.x_i(cnb_x),   .neg_i(cnb_neg), .y_o(cnb_y));
    mds_cneg #(.N(W))   u_cneg_r (.x_i(rem_fix), .neg_i(rneg_q),  .y_o(cnr_y));

    assign mul_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign div_b   = {2'b00, mcand_q[W-1:0]};
    assign rem_sh  = {rem_q[W:0], mplier_q[W-1]};
    assign rem_nx  = rem_q[W+1] ? (rem_sh + div_b) : (rem_sh - div_b);
    // A negative final partial remainder is one divisor short.
    assign rem_fix = rem_q[W-1:0] + (rem_q[W+1] ? mcand_q[W-1:0] : '0);

    // Quotient must fit: unsigned needs hi < b, signed keeps |q| below 2^(W-1).
    assign nd = is_sgn ? (cna_y >= ({{W{1'b0}}, cnb_y} << (W - 1)))
                       : (a_hi_q >= b_q);

`ifdef EDP_MDS_EARLY_OUT_EN
    assign run_last = (cnt_q == CNT_LAST) || (!is_div && ((mplier_q >> 1) == '0));
`else
    assign run_last = (cnt_q == CNT_LAST);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_MULU;
            a_hi_q         <= '0;
            a_lo_q         <= '0;
            b_q            <= '0;
            prod_q         <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            rem_q          <= '0;
            qneg_q         <= 1'b0;
            rneg_q         <= 1'b0;
            cnt_q          <= '0;
            start_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            nodiv_q        <= 1'b0;
            res_hi_q       <= '0;
            res_lo_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        op_q          <= op_e'(op);
                        a_hi_q        <= a_hi;
                        a_lo_q        <= a_lo;
                        b_q           <= b;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    cnt_q <= '0;
                    if (is_div) begin
                        nodiv_q  <= nd;
                        rem_q    <= {2'b00, cna_y[2*W-1:W]};
                        mplier_q <= cna_y[W-1:0];
                        mcand_q  <= {{W{1'b0}}, cnb_y};
                        qneg_q   <= is_sgn & (a_hi_q[W-1] ^ b_q[W-1]);
                        rneg_q   <= is_sgn & a_hi_q[W-1];
                        state_q  <= nd ? ST_FIX : ST_RUN;
                    end else begin
                        nodiv_q  <= 1'b0;
                        prod_q   <= '0;
                        mcand_q  <= cna_y;
                        mplier_q <= cnb_y;
                        qneg_q   <= is_sgn & (a_lo_q[W-1] ^ b_q[W-1]);
                        rneg_q   <= 1'b0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (is_div) begin
                        rem_q    <= rem_nx;
                        mplier_q <= {mplier_q[W-2:0], ~rem_nx[W+1]};
                    end else begin
                        prod_q   <= mul_sum;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                    if (run_last) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    if (nodiv_q) begin
                        res_hi_q <= a_hi_q;
                        res_lo_q <= a_lo_q;
                    end else if (is_div) begin
                        res_hi_q <= cnb_y;
                        res_lo_q <= cnr_y;
                    end else begin
                        {res_hi_q, res_lo_q} <= cna_y;
                    end
                    result_valid_q <= 1'b1;
                    state_q        <= ST_DONE;
                end
                ST_DONE: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        start_ready_q  <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign start_ready  = start_ready_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign nodiv        = nodiv_q;
    assign res_hi       = res_hi_q;
    assign res_lo       = res_lo_q;

endmodule

// File: tb/tb_edp_mds.sv
// Randomized scoreboard bench for edp_mds (WIDTH=36) against a wide-arithmetic model.
module tb_edp_mds;

    localparam int W = 36;

    logic         clk = 1'b0;
    logic         reset_n, start_valid, result_ready;
    logic [1:0]   op;
    logic [W-1:0] a_hi, a_lo, b, res_hi, res_lo;
    logic         start_ready, result_valid, nodiv, busy;

    edp_mds #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .a_hi(a_hi), .a_lo(a_lo), .b(b), .result_valid(result_valid),
        .result_ready(result_ready), .res_hi(res_hi), .res_lo(res_lo), .nodiv(nodiv), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         nd;
        int           lat;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] bb, input logic nd);
`ifdef EDP_MDS_EARLY_OUT_EN
        logic [W-1:0] mag;
        int n;
`endif
        if (nd) return 2;
`ifdef EDP_MDS_EARLY_OUT_EN
        if (!o[1]) begin
            mag = (o[0] && bb[W-1]) ? -bb : bb;
            n = 0;
            for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
            return 2 + ((n == 0) ? 1 : n);
        end
`endif
        return W + 2;
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] ah, al, bb);
        exp_t e;
        logic [2*W-1:0] ud, ub, p, ad, ab;
        logic signed [2*W-1:0] sd, sb, sq, sr;
        e.nd = 1'b0; e.acc = 0; e.hi = '0; e.lo = '0;
        ud = {ah, al};
        ub = {{W{1'b0}}, bb};
        sd = $signed(ud);
        sb = $signed({{W{bb[W-1]}}, bb});
        case (o)
            2'b00: begin p = {{W{1'b0}}, al} * ub; {e.hi, e.lo} = p; end
            2'b01: begin sq = $signed({{W{al[W-1]}}, al}) * sb; {e.hi, e.lo} = sq; end
            2'b10: begin
                if (ah >= bb) begin e.nd = 1'b1; e.hi = ah; e.lo = al; end
                else begin p = ud / ub; e.hi = p[W-1:0]; p = ud % ub; e.lo = p[W-1:0]; end
            end
            default: begin
                ad = (sd < 0) ? -sd : sd;
                ab = (sb < 0) ? -sb : sb;
                if (bb == '0 || ad >= (ab << (W - 1))) begin e.nd = 1'b1; e.hi = ah; e.lo = al; end
                else begin sq = sd / sb; sr = sd % sb; e.hi = sq[W-1:0]; e.lo = sr[W-1:0]; end
            end
        endcase
        e.lat = exp_lat(o, bb, e.nd);
        return e;
    endfunction

    // Waits for IDLE (throwing junk requests meanwhile), then issues one request.
    task automatic drive(input logic [1:0] o, input logic [W-1:0] ah, al, bb, output bit ok);
        int t = 0;
        while (!start_ready && t < 1000) begin
            start_valid = 1'($urandom());
            op = 2'($urandom()); a_hi = rnd(); a_lo = rnd(); b = rnd();
            @(negedge clk);
            t++;
        end
        ok = start_ready;
        if (!ok) begin
            chk("start_ready_wait", 144'(start_ready), 144'(1));
            start_valid = 1'b0;
            return;
        end
        start_valid = 1'b1; op = o; a_hi = ah; a_lo = al; b = bb;
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic run_model(input logic [1:0] o, input logic [W-1:0] ah, al, bb);
        bit ok;
        exp_t e;
        drive(o, ah, al, bb, ok);
        if (ok) begin e = model(o, ah, al, bb); e.acc = cyc; exp_q.push_back(e); end
    endtask

    task automatic run_fixed(input logic [1:0] o, input logic [W-1:0] ah, al, bb,
                             input logic [W-1:0] xhi, xlo, input logic xnd);
        bit ok;
        exp_t e;
        drive(o, ah, al, bb, ok);
        if (ok) begin
            e.hi = xhi; e.lo = xlo; e.nd = xnd; e.lat = exp_lat(o, bb, xnd); e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !start_ready) && t < 3000) begin @(negedge clk); t++; end
        chk("drain", 144'(exp_q.size()), 144'(0));
    endtask

    // Monitor: pops on the first cycle each result is valid, then checks it holds until taken.
    initial begin
        bit hold = 0;
        logic [2*W:0] held;
        exp_t e;
        result_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold = 0;
                result_ready = 1'b0;
            end else if (result_valid) begin
                if (!hold) begin
                    if (exp_q.size() == 0) chk("unexpected_result", 144'(exp_q.size()), 144'(1));
                    else begin
                        e = exp_q.pop_front();
                        chk("res_hi", 144'(res_hi), 144'(e.hi));
                        chk("res_lo", 144'(res_lo), 144'(e.lo));
                        chk("nodiv", 144'(nodiv), 144'(e.nd));
                        chk("latency", 144'(cyc - e.acc), 144'(e.lat));
                    end
                    hold = 1;
                    held = {res_hi, res_lo, nodiv};
                end else begin
                    chk("hold_stable", 144'({res_hi, res_lo, nodiv}), 144'(held));
                end
                result_ready = ($urandom_range(0, 2) == 0);
                if (result_ready) hold = 0;
            end else begin
                result_ready = 1'($urandom());
            end
        end
    end

    initial begin
        bit ok;
        logic [63:0] t;
        logic [1:0] o;
        logic [W-1:0] ah, al, bb;
        logic [2*W-1:0] dd;
        reset_n = 1'b0; start_valid = 1'b0; op = 2'b00; a_hi = '0; a_lo = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready_busy", 144'({start_ready, busy}), 144'(2'b10));
        chk("rst_valid_nodiv", 144'({result_valid, nodiv}), 144'(2'b00));
        chk("rst_res", 144'({res_hi, res_lo}), 144'(0));
        reset_n = 1'b1;

        run_fixed(2'b00, '0, 36'd3, 36'd5, '0, 36'd15, 1'b0);
        run_fixed(2'b01, '0, 36'o400000000000, 36'o400000000000, 36'o200000000000, '0, 1'b0);
        run_fixed(2'b01, '0, '1, '1, '0, 36'd1, 1'b0);
        run_fixed(2'b11, '0, 36'd100, -36'sd7, 36'o777777777762, 36'd2, 1'b0);
        run_fixed(2'b10, 36'd1, 36'd2, '0, 36'd1, 36'd2, 1'b1);
        run_fixed(2'b10, 36'd5, 36'd9, 36'd5, 36'd5, 36'd9, 1'b1);
        run_fixed(2'b11, '1, 36'd4, '0, '1, 36'd4, 1'b1);
        run_fixed(2'b00, '0, 36'd7, 36'd1, '0, 36'd7, 1'b0);
        run_fixed(2'b00, '0, 36'd7, '0, '0, '0, 1'b0);
        drain();

        // Reset in RUN cycle 10 discards the operation.
        drive(2'b00, '0, 36'd5, '1, ok);
        repeat (10) @(negedge clk);
        chk("mid_run_busy", 144'({busy, start_ready}), 144'(2'b10));
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_valid", 144'({start_ready, result_valid, busy}), 144'(3'b100));
        chk("mid_rst_res", 144'({res_hi, res_lo, nodiv}), 144'(0));
        reset_n = 1'b1;
        run_fixed(2'b00, '0, 36'd2, 36'd2, '0, 36'd4, 1'b0);
        drain();

        for (int n = 0; n < 150; n++) begin
            o = 2'($urandom());
            ah = rnd(); al = rnd(); bb = rnd();
            case ($urandom_range(0, 3))
                0: begin ah = 36'($urandom_range(0, 15)); al = 36'($urandom_range(0, 255));
                         bb = 36'($urandom_range(0, 15)); if (o[0]) bb = -bb; end
                1: begin
                    if (o == 2'b10) ah = (bb == '0) ? '0 : ah % bb;
                    if (o == 2'b11) begin
                        t = {$urandom(), $urandom()};
                        dd = {{(2*W-40){t[39]}}, t[39:0]};
                        {ah, al} = dd;
                        bb[W-2:10] = bb[W-2:10] | 1'b1;
                    end
                end
                default: ;
            endcase
            run_model(o, ah, al, bb);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
